// File: rtl/ctu_clsp_pkg.sv
// ---------------------------------------------------------------------------
// ctu_clsp_pkg
// Shared definitions for the CTU clock-spine generator blocks: the divider
// FSM state encoding and the default divider parameters.
// ---------------------------------------------------------------------------
package ctu_clsp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } ctu_state_t;

   localparam int CTU_DIV_W_DFLT     = 5;
   localparam int CTU_RST_RATIO_DFLT = 2;

endpackage : ctu_clsp_pkg

// File: rtl/ctu_clsp_clkgn_ndiv_if.sv
// ---------------------------------------------------------------------------
// ctu_clsp_clkgn_ndiv_if
// Control/status bundle of the domain-clock divider.
//   div_ratio  : requested divide ratio (0 is treated as 1)
//   div_ld     : 1-cycle load strobe for div_ratio
//   div_ld_ack : 1-cycle pulse in the first cycle of the new ratio's period
//   stretch_l  : low freezes the divider for that cycle
//   dom_div    : divided domain clock
//   align_edge : 1-cycle pulse, the next cycle is a dom_div rising edge
//   cur_ratio  : ratio currently in force
// master = ratio/stretch controller, slave = divider.
// ---------------------------------------------------------------------------
import ctu_clsp_pkg::*;

interface ctu_clsp_clkgn_ndiv_if #(
   parameter int DIV_W = CTU_DIV_W_DFLT
);
   logic [DIV_W-1:0] div_ratio;
   logic             div_ld;
   logic             div_ld_ack;
   logic             stretch_l;
   logic             dom_div;
   logic             align_edge;
   logic [DIV_W-1:0] cur_ratio;

   modport master (
      output div_ratio, div_ld, stretch_l,
      input  div_ld_ack, dom_div, align_edge, cur_ratio
   );

   modport slave (
      input  div_ratio, div_ld, stretch_l,
      output div_ld_ack, dom_div, align_edge, cur_ratio
   );
endinterface : ctu_clsp_clkgn_ndiv_if

// File: rtl/ctu_clsp_ratio_shadow.sv
// ---------------------------------------------------------------------------
// ctu_clsp_ratio_shadow
// Holds the requested divide ratio until the divider reaches a period
// boundary. A load clamps 0 to 1 and marks the shadow pending; the pending
// ratio is released at the next non-stretched wrap.
//   clk, init_l : clock, synchronous active-low reset
//   div_ld      : load strobe, div_ratio : requested ratio
//   wrap        : divider is wrapping this cycle (already qualified by stretch)
//   shadow      : ratio to apply, pend : shadow not yet applied
//   apply       : combinational strobe, switch to shadow at this wrap
//   ack         : registered apply, high in cnt=0 of the new period
// ---------------------------------------------------------------------------
import ctu_clsp_pkg::*;

module ctu_clsp_ratio_shadow #(
   parameter int DIV_W     = CTU_DIV_W_DFLT,
   parameter int RST_RATIO = CTU_RST_RATIO_DFLT
) (
   input  logic             clk,
   input  logic             init_l,
   input  logic             div_ld,
   input  logic [DIV_W-1:0] div_ratio,
   input  logic             wrap,
   output logic [DIV_W-1:0] shadow,
   output logic             pend,
   output logic             apply,
   output logic             ack
);

   // A load landing on a wrap edge defers to the following wrap, so the
   // latest requested value is the only one ever applied.
   always_comb apply = wrap & pend & ~div_ld;

   always_ff @(posedge clk) begin
      if (!init_l) begin
         shadow <= DIV_W'(RST_RATIO);
         pend   <= 1'b0;
         ack    <= 1'b0;
      end else begin
         ack <= apply;
         if (div_ld) begin
            shadow <= (div_ratio == '0) ? DIV_W'(1) : div_ratio;
            pend   <= 1'b1;
         end else if (apply) begin
            pend   <= 1'b0;
         end
      end
   end

endmodule : ctu_clsp_ratio_shadow

// File: rtl/ctu_clsp_clkgn_ndiv.sv
// ---------------------------------------------------------------------------
// ctu_clsp_clkgn_ndiv
// Domain-clock divider for the CTU clock spine. Divides pll_clk by a binary
// ratio R (high ceil(R/2) cycles, low floor(R/2)), supports glitch-free
// ratio change at period boundaries, per-cycle stretch, and an align_edge
// pulse one cycle ahead of every dom_div rising edge.
//   pll_clk : sole clock
//   init_l  : synchronous active-low reset
//   bus     : control/status bundle (slave side)
// All outputs come straight from flops: the next-cycle counter value is
// decoded here and registered alongside the counter.
// ---------------------------------------------------------------------------
import ctu_clsp_pkg::*;

module ctu_clsp_clkgn_ndiv #(
   parameter int DIV_W     = CTU_DIV_W_DFLT,
   parameter int RST_RATIO = CTU_RST_RATIO_DFLT
) (
   input  logic                  pll_clk,
   input  logic                  init_l,
   ctu_clsp_clkgn_ndiv_if.slave  bus
);

   ctu_state_t       state, state_nxt;
   logic [DIV_W-1:0] cnt, cnt_nxt;
   logic [DIV_W-1:0] ratio, ratio_nxt;
   logic [DIV_W-1:0] shadow;
   logic             pend, apply, ack;
   logic             wrap;
   logic             dom_div_q, align_q;

   // High-phase length ceil(R/2), formed in DIV_W+1 bits so R=2**DIV_W-1
   // does not overflow before the shift.
   function automatic logic [DIV_W-1:0] hi_of(input logic [DIV_W-1:0] r);
      logic [DIV_W:0] t;
      t = {1'b0, r} + (DIV_W+1)'(1);
      return t[DIV_W:1];
   endfunction

   always_comb wrap = (state != IDLE) && bus.stretch_l && (cnt == ratio - DIV_W'(1));

   ctu_clsp_ratio_shadow #(
      .DIV_W     (DIV_W),
      .RST_RATIO (RST_RATIO)
   ) u_shadow (
      .clk       (pll_clk),
      .init_l    (init_l),
      .div_ld    (bus.div_ld),
      .div_ratio (bus.div_ratio),
      .wrap      (wrap),
      .shadow    (shadow),
      .pend      (pend),
      .apply     (apply),
      .ack       (ack)
   );

   always_comb begin
      cnt_nxt   = cnt + DIV_W'(1);
      ratio_nxt = ratio;
      state_nxt = (bus.div_ld || (pend && !apply)) ? PEND : RUN;
      if (state == IDLE || wrap) cnt_nxt = '0;
      if (apply) ratio_nxt = shadow;
   end

   // Stretch freezes counter, clock level and state; only the one-cycle
   // strobes are forced low so align_edge is never repeated.
   always_ff @(posedge pll_clk) begin
      if (!init_l) begin
         state     <= IDLE;
         cnt       <= '0;
         ratio     <= DIV_W'(RST_RATIO);
         dom_div_q <= 1'b0;
         align_q   <= 1'b0;
      end else if (!bus.stretch_l) begin
         align_q   <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         ratio     <= ratio_nxt;
         dom_div_q <= (cnt_nxt < hi_of(ratio_nxt));
         align_q   <= (cnt_nxt == ratio_nxt - DIV_W'(1));
      end
   end

   assign bus.dom_div    = dom_div_q;
   assign bus.align_edge = align_q;
   assign bus.div_ld_ack = ack;
   assign bus.cur_ratio  = ratio;

endmodule : ctu_clsp_clkgn_ndiv

// File: tb/tb_ctu_clsp_clkgn_ndiv.sv
// ---------------------------------------------------------------------------
// tb_ctu_clsp_clkgn_ndiv
// Directed bench for the domain-clock divider (DIV_W=5, RST_RATIO=4).
// Each vector drives one cycle of inputs and queues the hand-derived outputs
// for the cycle after the edge; a monitor pops and compares them.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ctu_clsp_clkgn_ndiv;

   localparam int DIV_W = 5;

   typedef struct {
      int             idx;
      logic           dd;
      logic           ae;
      logic           ak;
      logic [DIV_W-1:0] cr;
   } exp_t;

   logic clk = 1'b0;
   logic init_l;
   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;
   int   vec    = 0;
   bit   done   = 1'b0;

   always #5 clk = ~clk;

   ctu_clsp_clkgn_ndiv_if #(.DIV_W(DIV_W)) bus ();

   ctu_clsp_clkgn_ndiv #(
      .DIV_W     (DIV_W),
      .RST_RATIO (4)
   ) dut (
      .pll_clk (clk),
      .init_l  (init_l),
      .bus     (bus.slave)
   );

   task automatic chk(input string name, input int idx, input logic [DIV_W-1:0] act,
                      input logic [DIV_W-1:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, req);
   endtask

   // Monitor: one output sample per cycle, 1 ns after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("dom_div",    e.idx, DIV_W'(bus.dom_div),    DIV_W'(e.dd));
            chk("align_edge", e.idx, DIV_W'(bus.align_edge), DIV_W'(e.ak & 1'b0 | e.ae));
            chk("div_ld_ack", e.idx, DIV_W'(bus.div_ld_ack), DIV_W'(e.ak));
            chk("cur_ratio",  e.idx, bus.cur_ratio,          e.cr);
         end
      end
   end

   // One cycle: drive inputs, queue the outputs expected after the edge.
   task automatic st(input logic il, input logic sl, input logic ld, input logic [DIV_W-1:0] r,
                     input logic dd, input logic ae, input logic ak, input logic [DIV_W-1:0] cr);
      exp_t e;
      init_l        = il;
      bus.stretch_l = sl;
      bus.div_ld    = ld;
      bus.div_ratio = r;
      e.idx = vec; e.dd = dd; e.ae = ae; e.ak = ak; e.cr = cr;
      q.push_back(e);
      vec++;
      @(posedge clk);
      #3;
   endtask

   initial begin
      init_l        = 1'b0;
      bus.stretch_l = 1'b1;
      bus.div_ld    = 1'b0;
      bus.div_ratio = '0;

      // reset values
      st(0,1,0,0, 0,0,0,4);
      st(0,1,0,0, 0,0,0,4);
      // 1: R=4 free-running, first cycle after release is high
      for (int k = 0; k < 2; k++) begin
         st(1,1,0,0, 1,0,0,4);
         st(1,1,0,0, 1,0,0,4);
         st(1,1,0,0, 0,0,0,4);
         st(1,1,0,0, 0,1,0,4);
      end
      // 2: load 5 mid-period; old period completes, then 1,1,1,0,0
      st(1,1,0,0, 1,0,0,4);
      st(1,1,1,5, 1,0,0,4);
      st(1,1,0,0, 0,0,0,4);
      st(1,1,0,0, 0,1,0,4);
      st(1,1,0,0, 1,0,1,5);
      st(1,1,0,0, 1,0,0,5);
      st(1,1,0,0, 1,0,0,5);
      st(1,1,0,0, 0,0,0,5);
      st(1,1,0,0, 0,1,0,5);
      // 3: loads 3 then 7 while pending; only 7 applied, one ack
      st(1,1,0,0, 1,0,0,5);
      st(1,1,1,3, 1,0,0,5);
      st(1,1,1,7, 1,0,0,5);
      st(1,1,0,0, 0,0,0,5);
      st(1,1,0,0, 0,1,0,5);
      st(1,1,0,0, 1,0,1,7);
      st(1,1,0,0, 1,0,0,7);
      st(1,1,0,0, 1,0,0,7);
      st(1,1,0,0, 1,0,0,7);
      st(1,1,0,0, 0,0,0,7);
      st(1,1,0,0, 0,0,0,7);
      st(1,1,0,0, 0,1,0,7);
      st(1,1,0,0, 1,0,0,7);
      // back to R=4
      st(1,1,1,4, 1,0,0,7);
      st(1,1,0,0, 1,0,0,7);
      st(1,1,0,0, 1,0,0,7);
      st(1,1,0,0, 0,0,0,7);
      st(1,1,0,0, 0,0,0,7);
      st(1,1,0,0, 0,1,0,7);
      st(1,1,0,0, 1,0,1,4);
      // 4: stretch 2 cycles at cnt=1 -> high 4 cycles, period 6
      st(1,1,0,0, 1,0,0,4);
      st(1,0,0,0, 1,0,0,4);
      st(1,0,0,0, 1,0,0,4);
      st(1,1,0,0, 0,0,0,4);
      st(1,1,0,0, 0,1,0,4);
      st(1,1,0,0, 1,0,0,4);
      // stretch on cnt=R-1: align_edge not repeated, no wrap
      st(1,1,0,0, 1,0,0,4);
      st(1,1,0,0, 0,0,0,4);
      st(1,1,0,0, 0,1,0,4);
      st(1,0,0,0, 0,0,0,4);
      st(1,1,0,0, 1,0,0,4);
      // load on the wrap cycle applies at the following wrap
      st(1,1,0,0, 1,0,0,4);
      st(1,1,0,0, 0,0,0,4);
      st(1,1,0,0, 0,1,0,4);
      st(1,1,1,2, 1,0,0,4);
      st(1,1,0,0, 1,0,0,4);
      st(1,1,0,0, 0,0,0,4);
      st(1,1,0,0, 0,1,0,4);
      st(1,1,0,0, 1,0,1,2);
      st(1,1,0,0, 0,1,0,2);
      st(1,1,0,0, 1,0,0,2);
      // 5: ratio 0 -> bypass (R=1)
      st(1,1,1,0, 0,1,0,2);
      st(1,1,0,0, 1,1,1,1);
      st(1,1,0,0, 1,1,0,1);
      st(1,1,0,0, 1,1,0,1);
      // reload equal ratio 1 in bypass: still acked, waveform unchanged
      st(1,1,1,1, 1,1,0,1);
      st(1,1,0,0, 1,1,1,1);
      st(1,1,0,0, 1,1,0,1);
      st(1,0,0,0, 1,0,0,1);
      st(1,1,0,0, 1,1,0,1);
      // 6: back to R=4, then reset with a load pending
      st(1,1,1,4, 1,1,0,1);
      st(1,1,0,0, 1,0,1,4);
      st(1,1,0,0, 1,0,0,4);
      st(1,1,1,3, 0,0,0,4);
      st(0,1,0,0, 0,0,0,4);
      st(1,1,0,0, 1,0,0,4);
      st(1,1,0,0, 1,0,0,4);
      st(1,1,0,0, 0,0,0,4);
      st(1,1,0,0, 0,1,0,4);
      st(1,1,0,0, 1,0,0,4);
      st(1,1,0,0, 1,0,0,4);

      for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
      #2;
      n_chk++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expectations left, expected 0", q.size());
      done = 1'b1;
   end

   initial begin
      wait (done);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: bench did not complete, expected completion");
      $fatal(1);
   end

endmodule : tb_ctu_clsp_clkgn_ndiv
